// File: rtl/phi1_phase_lock.sv
// PHI1 -> C14M synchronizer, period checker and slot counter for the SDRAM sequencer.
// S is only driven while PHI1 rises exactly PERIOD C14M cycles apart.
module phi1_phase_lock #(
  parameter int PERIOD     = 14,
  parameter int LOCK_COUNT = 4
) (
  input  logic       C14M,
  input  logic       Reset,
  input  logic       PHI1,
  output logic [3:0] S,
  output logic       PHI1Rise,
  output logic       Locked,
  output logic [7:0] ErrCount
);

  localparam logic [4:0] PER  = 5'(PERIOD);
  localparam logic [4:0] LCNT = 5'(LOCK_COUNT);
  localparam logic [4:0] TMO  = 5'd30;

  // sync[0]=P1a, sync[1]=P1b, sync[2]=P1c
  logic [2:0] sync;
  logic       r;
  logic [4:0] cnt;
  logic       seen;
  logic [3:0] good;

  logic       locked_nxt;
  logic [3:0] good_nxt;
  logic [4:0] good_p1;
  logic       err_inc;
  logic [3:0] s_nxt;

  assign r = sync[1] & ~sync[2];

  always_comb begin
    locked_nxt = Locked;
    good_nxt   = good;
    err_inc    = 1'b0;
    good_p1    = {1'b0, good} + 5'd1;
    if (r && seen) begin
      if (cnt == PER) begin
        good_nxt = (good_p1 >= LCNT) ? LCNT[3:0] : good_p1[3:0];
        if (good_p1 >= LCNT) locked_nxt = 1'b1;
      end else begin
        good_nxt = 4'd0;
        if (Locked) begin
          locked_nxt = 1'b0;
          err_inc    = 1'b1;
        end
      end
    end else if (!r && cnt == TMO && Locked) begin
      // cnt moves on to 31 next cycle, so this fires once per silence
      locked_nxt = 1'b0;
      good_nxt   = 4'd0;
      err_inc    = 1'b1;
    end
  end

  always_comb begin
    s_nxt = S;
    if (!locked_nxt)                s_nxt = 4'd0;
    else if (r)                     s_nxt = 4'd1;
    else if (S != 4'd0 && S != 4'd15) s_nxt = S + 4'd1;
  end

  always_ff @(posedge C14M) begin
    if (Reset) begin
      sync     <= '0;
      cnt      <= '0;
      seen     <= 1'b0;
      good     <= '0;
      Locked   <= 1'b0;
      ErrCount <= '0;
      S        <= '0;
      PHI1Rise <= 1'b0;
    end else begin
      sync     <= {sync[1:0], PHI1};
      PHI1Rise <= r;
      cnt      <= r ? 5'd1 : ((cnt == 5'd31) ? cnt : cnt + 5'd1);
      seen     <= seen | r;
      good     <= good_nxt;
      Locked   <= locked_nxt;
      S        <= s_nxt;
      if (err_inc && ErrCount != 8'hFF) ErrCount <= ErrCount + 8'd1;
    end
  end

endmodule
